// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage controller between the XM and MW pipeline
// registers. It turns an XM load/store into a level-held req/ready
// transaction on a variable-latency data memory and stalls the pipeline
// until the access completes.
//
// Handshake: req_dmem rises on the edge that enters WAIT. It stays high, with
// address/data/wren stable, until the first WAIT cycle in which dmem_ready=1
// is sampled on a rising edge. That edge is the transfer. dmem_ready is
// ignored in every other state.
//
// Optional build macro MEM_TIMEOUT_EN: a transaction is aborted after
// TIMEOUT_CYCLES WAIT cycles without ready. The abort returns q_mem=0 and
// raises mem_fault for the DONE cycle(s). Without the macro, WAIT can last
// indefinitely and mem_fault is tied low.
module mem_access_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] aluOut_from_xm,
   input  logic [DATA_WIDTH-1:0] data_from_xm,
   input  logic                  MemRead_from_xm,
   input  logic                  MemWrite_from_xm,
   input  logic                  stall,
   output logic [ADDR_WIDTH-1:0] address_dmem,
   output logic [DATA_WIDTH-1:0] data_dmem,
   output logic                  wren_dmem,
   output logic                  req_dmem,
   input  logic                  dmem_ready,
   input  logic [DATA_WIDTH-1:0] q_dmem,
   output logic [DATA_WIDTH-1:0] q_mem,
   output logic                  stall_mem,
   output logic                  mem_fault,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    wren_q, wren_d;
   logic                    req_q, req_d;
   logic [DATA_WIDTH-1:0]   q_mem_q, q_mem_d;
   logic                    mem_op;

   // The upper address bits select nothing in the word-addressed dmem.
   logic unused_addr_bits;
   assign unused_addr_bits = ^aluOut_from_xm[DATA_WIDTH-1:ADDR_WIDTH];

   assign mem_op = MemRead_from_xm | MemWrite_from_xm;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             fault_q, fault_d;
`else
   localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
`endif

   // Next-state, registered-output and stall logic for the IDLE/WAIT/DONE FSM.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      wren_d    = wren_q;
      req_d     = req_q;
      q_mem_d   = q_mem_q;
      stall_mem = 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
      fault_d    = fault_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (mem_op) begin
               stall_mem = 1'b1;
               addr_d    = aluOut_from_xm[ADDR_WIDTH-1:0];
               data_d    = data_from_xm;
               // A load+store collision is treated as a store.
               wren_d    = MemWrite_from_xm;
               req_d     = 1'b1;
               state_d   = S_WAIT;
`ifdef MEM_TIMEOUT_EN
               wait_cnt_d = '0;
`endif
            end
         end
         S_WAIT: begin
            stall_mem = 1'b1;
            if (dmem_ready) begin
               if (!wren_q) begin
                  q_mem_d = q_dmem;
               end
               req_d   = 1'b0;
               wren_d  = 1'b0;
               state_d = S_DONE;
`ifdef MEM_TIMEOUT_EN
               fault_d = 1'b0;
            end else if (wait_cnt_q == CNT_LAST) begin
               q_mem_d = '0;
               req_d   = 1'b0;
               wren_d  = 1'b0;
               fault_d = 1'b1;
               state_d = S_DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
`endif
            end
         end
         S_DONE: begin
            // XM/MW advance on this edge unless the downstream freeze holds us.
            if (!stall) begin
               state_d = S_IDLE;
`ifdef MEM_TIMEOUT_EN
               fault_d = 1'b0;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Nothing is stalled while reset is held, even with an op waiting in XM.
      if (reset) begin
         stall_mem = 1'b0;
      end
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         wren_q  <= 1'b0;
         req_q   <= 1'b0;
         q_mem_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wren_q  <= wren_d;
         req_q   <= req_d;
         q_mem_q <= q_mem_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   // WAIT-cycle counter and fault flag for the timeout abort.
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         fault_q    <= fault_d;
      end
   end
   assign mem_fault = fault_q;
`else
   assign mem_fault = 1'b0;
`endif

   assign address_dmem = addr_q;
   assign data_dmem    = data_q;
   assign wren_dmem    = wren_q;
   assign req_dmem     = req_q;
   assign q_mem        = q_mem_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: reset, non-memory ops, loads and stores
// at several ready latencies, reset mid-WAIT, downstream freeze in DONE and,
// with MEM_TIMEOUT_EN, the timeout abort (TIMEOUT_CYCLES=4).
module tb_mem_access_ctrl;

   localparam int DW = 32;
   localparam int AW = 12;
`ifdef MEM_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 16;
`endif

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic          clock = 1'b0;
   logic          reset;
   logic [DW-1:0] alu_out;
   logic [DW-1:0] data_xm;
   logic          mem_read;
   logic          mem_write;
   logic          stall;
   logic [AW-1:0] address_dmem;
   logic [DW-1:0] data_dmem;
   logic          wren_dmem;
   logic          req_dmem;
   logic          dmem_ready;
   logic [DW-1:0] q_dmem;
   logic [DW-1:0] q_mem;
   logic          stall_mem;
   logic          mem_fault;
   logic [1:0]    dbg_state;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;

   mem_access_ctrl #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .aluOut_from_xm  (alu_out),
      .data_from_xm    (data_xm),
      .MemRead_from_xm (mem_read),
      .MemWrite_from_xm(mem_write),
      .stall           (stall),
      .address_dmem    (address_dmem),
      .data_dmem       (data_dmem),
      .wren_dmem       (wren_dmem),
      .req_dmem        (req_dmem),
      .dmem_ready      (dmem_ready),
      .q_dmem          (q_dmem),
      .q_mem           (q_mem),
      .stall_mem       (stall_mem),
      .mem_fault       (mem_fault),
      .dbg_state       (dbg_state)
   );

   // Clock
   always #5 clock = ~clock;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction: issue in IDLE, ready after k WAIT cycles, hold DONE
   // for 'hold' extra cycles with stall=1, then return to IDLE.
   task automatic run_op(input string tag, input logic rd, input logic wr,
                         input logic [DW-1:0] alu, input logic [DW-1:0] dat,
                         input int k, input logic [DW-1:0] rdat,
                         input logic [DW-1:0] exp_q, input int hold);
      int stall_cnt;
      stall_cnt = 0;
      mem_read  = rd;
      mem_write = wr;
      alu_out   = alu;
      data_xm   = dat;
      #1;
      chk({tag, "_idle_stall"}, {31'd0, stall_mem}, 1);
      if (stall_mem) stall_cnt++;
      for (int i = 0; i <= k; i++) begin
         tick();
         chk({tag, "_wait_state"}, {30'd0, dbg_state}, {30'd0, ST_WAIT});
         chk({tag, "_wait_req"}, {31'd0, req_dmem}, 1);
         chk({tag, "_wait_addr"}, {20'd0, address_dmem}, {20'd0, alu[AW-1:0]});
         chk({tag, "_wait_wren"}, {31'd0, wren_dmem}, {31'd0, wr});
         if (wr) chk({tag, "_wait_data"}, data_dmem, dat);
         if (stall_mem) stall_cnt++;
         if (i == k) begin
            dmem_ready = 1'b1;
            q_dmem     = rdat;
         end
      end
      tick();
      dmem_ready = 1'b0;
      q_dmem     = 32'hA5A5_5A5A;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      #1;
      chk({tag, "_done_state"}, {30'd0, dbg_state}, {30'd0, ST_DONE});
      chk({tag, "_done_stall"}, {31'd0, stall_mem}, 0);
      chk({tag, "_done_req"}, {31'd0, req_dmem}, 0);
      chk({tag, "_done_wren"}, {31'd0, wren_dmem}, 0);
      chk({tag, "_done_qmem"}, q_mem, exp_q);
      chk({tag, "_done_fault"}, {31'd0, mem_fault}, 0);
      if (hold > 0) begin
         stall = 1'b1;
         for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_hold_state"}, {30'd0, dbg_state}, {30'd0, ST_DONE});
            chk({tag, "_hold_qmem"}, q_mem, exp_q);
            chk({tag, "_hold_stall"}, {31'd0, stall_mem}, 0);
         end
         stall = 1'b0;
      end
      tick();
      chk({tag, "_idle_state"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
      chk({tag, "_stall_cycles"}, stall_cnt, k + 2);
   endtask

   initial begin
      // 1. Reset with a pending load and a stray ready.
      reset      = 1'b1;
      alu_out    = 32'h0000_0FFF;
      data_xm    = 32'h1111_1111;
      mem_read   = 1'b1;
      mem_write  = 1'b0;
      stall      = 1'b0;
      dmem_ready = 1'b1;
      q_dmem     = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
         chk("rst_req", {31'd0, req_dmem}, 0);
         chk("rst_wren", {31'd0, wren_dmem}, 0);
         chk("rst_addr", {20'd0, address_dmem}, 0);
         chk("rst_data", data_dmem, 0);
         chk("rst_qmem", q_mem, 0);
         chk("rst_fault", {31'd0, mem_fault}, 0);
         chk("rst_stall", {31'd0, stall_mem}, 0);
      end
      reset      = 1'b0;
      dmem_ready = 1'b0;
      #1;
      chk("post_rst_stall", {31'd0, stall_mem}, 1);
      mem_read = 1'b0;
      #1;
      chk("post_rst_drop", {31'd0, stall_mem}, 0);

      // 2. Non-memory instructions add no latency.
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("nomem_stall", {31'd0, stall_mem}, 0);
         chk("nomem_req", {31'd0, req_dmem}, 0);
      end

      // 3. Load with ready after 3 cycles.
      run_op("ld_k3", 1'b1, 1'b0, 32'h0000_0ABC, 32'h0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
      chk("ld_k3_req_after", {31'd0, req_dmem}, 0);

      // 4. Store then load back-to-back; a store leaves q_mem alone.
      run_op("st_k0", 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 0, 32'h5555_5555, 32'hDEAD_BEEF, 0);
      run_op("ld_k0", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);
      // Read+write together is a store; upper address bits are dropped.
      run_op("rw_k1", 1'b1, 1'b1, 32'hFFFF_F345, 32'h0F0F_0F0F, 1, 32'h7777_7777, 32'hCAFE_F00D, 0);

      // 5a. Reset during WAIT at k=2, then a late ready.
      mem_read = 1'b1;
      alu_out  = 32'h0000_0123;
      for (int i = 0; i < 3; i++) tick();
      chk("midrst_wait", {30'd0, dbg_state}, {30'd0, ST_WAIT});
      reset = 1'b1;
      tick();
      reset      = 1'b0;
      mem_read   = 1'b0;
      dmem_ready = 1'b1;
      q_dmem     = 32'h9999_9999;
      #1;
      chk("midrst_req", {31'd0, req_dmem}, 0);
      chk("midrst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      chk("midrst_qmem", q_mem, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("late_rdy_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
         chk("late_rdy_qmem", q_mem, 0);
         chk("late_rdy_req", {31'd0, req_dmem}, 0);
      end
      dmem_ready = 1'b0;

      // 5b. Downstream freeze holds DONE for 3 cycles.
      run_op("frz_k1", 1'b1, 1'b0, 32'h0000_0200, 32'h0, 1, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 3);

`ifdef MEM_TIMEOUT_EN
      // 6a. Load that never sees ready: 4 WAIT cycles, then a faulted DONE.
      mem_read = 1'b1;
      alu_out  = 32'h0000_03FF;
      #1;
      chk("to_idle_stall", {31'd0, stall_mem}, 1);
      for (int i = 0; i < TO; i++) begin
         tick();
         chk("to_wait_state", {30'd0, dbg_state}, {30'd0, ST_WAIT});
         chk("to_wait_req", {31'd0, req_dmem}, 1);
      end
      tick();
      mem_read = 1'b0;
      #1;
      chk("to_done_state", {30'd0, dbg_state}, {30'd0, ST_DONE});
      chk("to_done_fault", {31'd0, mem_fault}, 1);
      chk("to_done_qmem", q_mem, 0);
      chk("to_done_req", {31'd0, req_dmem}, 0);
      tick();
      chk("to_idle_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      chk("to_idle_fault", {31'd0, mem_fault}, 0);
      // 6b. Ready on the 4th WAIT cycle wins over the timeout.
      run_op("to_race", 1'b1, 1'b0, 32'h0000_0044, 32'h0, TO - 1, 32'h4444_ABCD, 32'h4444_ABCD, 0);
`else
      // Without the timeout, WAIT persists well beyond 16 cycles.
      run_op("long_k20", 1'b1, 1'b0, 32'h0000_0044, 32'h0, 20, 32'h4444_ABCD, 32'h4444_ABCD, 0);
      chk("long_fault", {31'd0, mem_fault}, 0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
